// File: rtl/gps_signal_gen.sv
// Two-channel C/A Gold code generator producing the 2-bit composite RX chip stream.
// Define GPS_SIGNAL_GEN_NOISE_EN to add pseudo-random chip erasure on RX.
module gps_signal_gen #(
  parameter int EPOCH_LEN = 1023,
  parameter int PHASE_W   = 10
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               LOAD,
  input  logic [3:0]         TAP_A1,
  input  logic [3:0]         TAP_A2,
  input  logic [3:0]         TAP_B1,
  input  logic [3:0]         TAP_B2,
  input  logic [PHASE_W-1:0] PHASE_A,
  input  logic [PHASE_W-1:0] PHASE_B,
  input  logic               ENABLE_B,
  input  logic               START,
  input  logic               STOP,
  output logic [1:0]         RX,
  output logic               VALID,
  output logic               EPOCH,
  output logic [PHASE_W-1:0] CHIP,
  output logic               BUSY,
  output logic               CFG_ERR
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALIGN = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  localparam logic [PHASE_W-1:0] PHASE_MAX = PHASE_W'(EPOCH_LEN - 1);
  localparam logic [PHASE_W-1:0] CHIP_LAST = PHASE_W'(EPOCH_LEN);
  localparam logic [PHASE_W-1:0] P_ZERO    = {PHASE_W{1'b0}};
  localparam logic [PHASE_W-1:0] P_ONE     = PHASE_W'(1);

  // Register bit i holds LFSR stage i+1; new stage 1 enters at bit 0.
  function automatic logic [9:0] g1_step(input logic [9:0] g);
    return {g[8:0], g[2] ^ g[9]};
  endfunction

  function automatic logic [9:0] g2_step(input logic [9:0] g);
    return {g[8:0], g[1] ^ g[2] ^ g[5] ^ g[7] ^ g[8] ^ g[9]};
  endfunction

  function automatic logic tap_sel(input logic [9:0] g, input logic [3:0] t);
    logic bit_s;
    case (t)
      4'd1:    bit_s = g[0];
      4'd2:    bit_s = g[1];
      4'd3:    bit_s = g[2];
      4'd4:    bit_s = g[3];
      4'd5:    bit_s = g[4];
      4'd6:    bit_s = g[5];
      4'd7:    bit_s = g[6];
      4'd8:    bit_s = g[7];
      4'd9:    bit_s = g[8];
      4'd10:   bit_s = g[9];
      default: bit_s = 1'b0;
    endcase
    return bit_s;
  endfunction

  function automatic logic tap_ok(input logic [3:0] t);
    return (t >= 4'd1) && (t <= 4'd10);
  endfunction

  state_t             state_r, state_next;
  logic               busy_r;
  logic [3:0]         tap_a1_r, tap_a2_r, tap_b1_r, tap_b2_r;
  logic [PHASE_W-1:0] phase_a_r, phase_b_r;
  logic               en_b_r;
  logic               cfg_err_r;
  logic [PHASE_W-1:0] align_cnt_r;
  logic [9:0]         g1_a_r, g2_a_r, g1_b_r, g2_b_r;
  logic [1:0]         rx_r;
  logic               valid_r, epoch_r;
  logic [PHASE_W-1:0] chip_r;

  logic               cfg_ok_s, load_acc_s, start_s, run_out_s, erase_s;
  logic [PHASE_W-1:0] eff_pa_s, eff_pb_s, reg_pb_s, align_last_s, chip_next_s;
  logic               chip_a_s, chip_b_s;
  logic [1:0]         rx_sum_s, rx_out_s;

  // Configuration validation and the phases a START in this cycle would use.
  always_comb begin
    cfg_ok_s = tap_ok(TAP_A1) && tap_ok(TAP_A2) && tap_ok(TAP_B1) && tap_ok(TAP_B2) &&
               (PHASE_A <= PHASE_MAX) && (PHASE_B <= PHASE_MAX) &&
               (TAP_A1 != TAP_A2) && (!ENABLE_B || (TAP_B1 != TAP_B2));
    load_acc_s = LOAD && (state_r == ST_IDLE) && cfg_ok_s;
    start_s    = (state_r == ST_IDLE) && START && !STOP;
    reg_pb_s   = en_b_r ? phase_b_r : P_ZERO;
    if (load_acc_s) begin
      eff_pa_s = PHASE_A;
      eff_pb_s = ENABLE_B ? PHASE_B : P_ZERO;
    end else begin
      eff_pa_s = phase_a_r;
      eff_pb_s = reg_pb_s;
    end
    if (phase_a_r > reg_pb_s) begin
      align_last_s = phase_a_r - P_ONE;
    end else begin
      align_last_s = reg_pb_s - P_ONE;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          if ((eff_pa_s == P_ZERO) && (eff_pb_s == P_ZERO)) begin
            state_next = ST_RUN;
          end else begin
            state_next = ST_ALIGN;
          end
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_ALIGN: begin
        if (STOP) begin
          state_next = ST_IDLE;
        end else if (align_cnt_r == align_last_s) begin
          state_next = ST_RUN;
        end else begin
          state_next = ST_ALIGN;
        end
      end
      ST_RUN: begin
        if (STOP) begin
          state_next = ST_IDLE;
        end else begin
          state_next = ST_RUN;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Chip generation, composite sum and optional erasure.
  always_comb begin
    chip_a_s = g1_a_r[9] ^ tap_sel(g2_a_r, tap_a1_r) ^ tap_sel(g2_a_r, tap_a2_r);
    chip_b_s = g1_b_r[9] ^ tap_sel(g2_b_r, tap_b1_r) ^ tap_sel(g2_b_r, tap_b2_r);
    if (!en_b_r) begin
      rx_sum_s = chip_a_s ? 2'b01 : 2'b11;
    end else if (chip_a_s && chip_b_s) begin
      rx_sum_s = 2'b01;
    end else if (!chip_a_s && !chip_b_s) begin
      rx_sum_s = 2'b11;
    end else begin
      rx_sum_s = 2'b00;
    end
    rx_out_s    = erase_s ? 2'b00 : rx_sum_s;
    chip_next_s = (chip_r == CHIP_LAST) ? P_ONE : (chip_r + P_ONE);
    run_out_s   = (state_r == ST_RUN) && !STOP;
  end

  // State register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_next;
      busy_r  <= (state_next != ST_IDLE);
    end
  end

  // Configuration latch; a rejected LOAD keeps the previous configuration.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      tap_a1_r  <= 4'd2;
      tap_a2_r  <= 4'd6;
      tap_b1_r  <= 4'd3;
      tap_b2_r  <= 4'd7;
      phase_a_r <= P_ZERO;
      phase_b_r <= P_ZERO;
      en_b_r    <= 1'b0;
      cfg_err_r <= 1'b0;
    end else if (LOAD && (state_r == ST_IDLE)) begin
      if (cfg_ok_s) begin
        tap_a1_r  <= TAP_A1;
        tap_a2_r  <= TAP_A2;
        tap_b1_r  <= TAP_B1;
        tap_b2_r  <= TAP_B2;
        phase_a_r <= PHASE_A;
        phase_b_r <= PHASE_B;
        en_b_r    <= ENABLE_B;
        cfg_err_r <= 1'b0;
      end else begin
        cfg_err_r <= 1'b1;
      end
    end
  end

  // Align counter and per-channel LFSRs; each channel only advances up to its own phase in ALIGN.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      align_cnt_r <= P_ZERO;
      g1_a_r      <= 10'h3FF;
      g2_a_r      <= 10'h3FF;
      g1_b_r      <= 10'h3FF;
      g2_b_r      <= 10'h3FF;
    end else if (start_s) begin
      align_cnt_r <= P_ZERO;
      g1_a_r      <= 10'h3FF;
      g2_a_r      <= 10'h3FF;
      g1_b_r      <= 10'h3FF;
      g2_b_r      <= 10'h3FF;
    end else if (state_r == ST_ALIGN) begin
      align_cnt_r <= align_cnt_r + P_ONE;
      if (align_cnt_r < phase_a_r) begin
        g1_a_r <= g1_step(g1_a_r);
        g2_a_r <= g2_step(g2_a_r);
      end
      if (align_cnt_r < reg_pb_s) begin
        g1_b_r <= g1_step(g1_b_r);
        g2_b_r <= g2_step(g2_b_r);
      end
    end else if (state_r == ST_RUN) begin
      g1_a_r <= g1_step(g1_a_r);
      g2_a_r <= g2_step(g2_a_r);
      g1_b_r <= g1_step(g1_b_r);
      g2_b_r <= g2_step(g2_b_r);
    end
  end

  // Registered chip outputs; anything other than an uninterrupted RUN cycle clears them.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rx_r    <= 2'b00;
      valid_r <= 1'b0;
      epoch_r <= 1'b0;
      chip_r  <= P_ZERO;
    end else if (run_out_s) begin
      rx_r    <= rx_out_s;
      valid_r <= 1'b1;
      epoch_r <= (chip_next_s == CHIP_LAST);
      chip_r  <= chip_next_s;
    end else begin
      rx_r    <= 2'b00;
      valid_r <= 1'b0;
      epoch_r <= 1'b0;
      chip_r  <= P_ZERO;
    end
  end

`ifdef GPS_SIGNAL_GEN_NOISE_EN
  logic [15:0] noise_r;

  always_comb begin
    erase_s = (noise_r[3:0] == 4'd0);
  end

  // Noise LFSR (taps 16,14,13,11) advances once per emitted chip.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      noise_r <= 16'hACE1;
    end else if (start_s) begin
      noise_r <= 16'hACE1;
    end else if (run_out_s) begin
      noise_r <= {noise_r[0] ^ noise_r[2] ^ noise_r[3] ^ noise_r[5], noise_r[15:1]};
    end
  end
`else
  always_comb begin
    erase_s = 1'b0;
  end
`endif

  assign RX      = rx_r;
  assign VALID   = valid_r;
  assign EPOCH   = epoch_r;
  assign CHIP    = chip_r;
  assign BUSY    = busy_r;
  assign CFG_ERR = cfg_err_r;

endmodule

// File: tb/tb_gps_signal_gen.sv
// Directed self-checking bench for gps_signal_gen against a behavioural Gold-code model.
module tb_gps_signal_gen;

  logic       CLK = 1'b0;
  logic       RESET_N, LOAD, ENABLE_B, START, STOP;
  logic [3:0] TAP_A1, TAP_A2, TAP_B1, TAP_B2;
  logic [9:0] PHASE_A, PHASE_B;
  logic [1:0] RX;
  logic       VALID, EPOCH, BUSY, CFG_ERR;
  logic [9:0] CHIP;

  gps_signal_gen #(.EPOCH_LEN(1023), .PHASE_W(10)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .LOAD(LOAD),
    .TAP_A1(TAP_A1), .TAP_A2(TAP_A2), .TAP_B1(TAP_B1), .TAP_B2(TAP_B2),
    .PHASE_A(PHASE_A), .PHASE_B(PHASE_B), .ENABLE_B(ENABLE_B),
    .START(START), .STOP(STOP), .RX(RX), .VALID(VALID), .EPOCH(EPOCH),
    .CHIP(CHIP), .BUSY(BUSY), .CFG_ERR(CFG_ERR)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0]   nz = 16'hACE1;
  logic          erase_now = 1'b0;
  logic [1022:0] seq_a, seq_b;
  int            nv;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Advance one clock and sample; the noise model advances on each emitted chip.
  task automatic tick();
    @(posedge CLK); #1;
    erase_now = 1'b0;
`ifdef GPS_SIGNAL_GEN_NOISE_EN
    if (VALID) begin
      erase_now = (nz[3:0] == 4'd0);
      nz = {nz[0] ^ nz[2] ^ nz[3] ^ nz[5], nz[15:1]};
    end
`endif
  endtask

  task automatic gen_prn(input int t1, input int t2, output logic [1022:0] seq);
    logic [10:1] g1, g2;
    logic f1, f2;
    g1 = '1;
    g2 = '1;
    for (int i = 0; i < 1023; i++) begin
      seq[i] = g1[10] ^ g2[t1] ^ g2[t2];
      f1 = g1[3] ^ g1[10];
      f2 = g2[2] ^ g2[3] ^ g2[6] ^ g2[8] ^ g2[9] ^ g2[10];
      g1 = {g1[9:1], f1};
      g2 = {g2[9:1], f2};
    end
  endtask

  function automatic logic [1:0] sum_rx(input logic a, input logic b, input logic en);
    if (!en) return a ? 2'b01 : 2'b11;
    if (a && b) return 2'b01;
    if (!a && !b) return 2'b11;
    return 2'b00;
  endfunction

  task automatic do_load(input int a1, input int a2, input int b1, input int b2,
                         input int pa, input int pb, input logic en);
    TAP_A1 = 4'(a1); TAP_A2 = 4'(a2); TAP_B1 = 4'(b1); TAP_B2 = 4'(b2);
    PHASE_A = 10'(pa); PHASE_B = 10'(pb); ENABLE_B = en;
    LOAD = 1'b1;
    tick();
    LOAD = 1'b0;
  endtask

  task automatic do_start();
    START = 1'b1;
    nz = 16'hACE1;
    tick();
    START = 1'b0;
  endtask

  task automatic do_stop();
    STOP = 1'b1;
    tick();
    STOP = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!VALID && n < 2000);
  endtask

  // Compares n consecutive chips from the current sample against the model sequences.
  task automatic run_check(input string tag, input int s, input int n, input int oa,
                           input int ob, input logic en, input logic bal_chk);
    int rx_err, chip_err, ep_err, obs_bal, exp_bal, ce;
    logic [1:0] exp_rx;
    rx_err = 0; chip_err = 0; ep_err = 0; obs_bal = 0; exp_bal = 0;
    for (int i = s; i < s + n; i++) begin
      exp_rx = sum_rx(seq_a[(i + oa) % 1023], seq_b[(i + ob) % 1023], en);
      if (erase_now) exp_rx = 2'b00;
      ce = (i % 1023) + 1;
      if (RX != exp_rx) rx_err++;
      if (!VALID || (int'(CHIP) != ce)) chip_err++;
      if (EPOCH != (ce == 1023)) ep_err++;
      if (RX == 2'b01) obs_bal++;
      if (RX == 2'b11) obs_bal--;
      if (exp_rx == 2'b01) exp_bal++;
      if (exp_rx == 2'b11) exp_bal--;
      if (i < s + n - 1) tick();
    end
    check({tag, "_rx_errs"}, rx_err, 0);
    check({tag, "_chip_errs"}, chip_err, 0);
    check({tag, "_epoch_errs"}, ep_err, 0);
    if (bal_chk) check({tag, "_balance"}, obs_bal, exp_bal);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int hv;
    logic [9:0] hand;
    RESET_N = 1'b0; LOAD = 1'b0; START = 1'b0; STOP = 1'b0; ENABLE_B = 1'b0;
    TAP_A1 = 4'd2; TAP_A2 = 4'd6; TAP_B1 = 4'd3; TAP_B2 = 4'd7;
    PHASE_A = 10'd0; PHASE_B = 10'd0;
    gen_prn(2, 6, seq_a);
    gen_prn(3, 7, seq_b);
    hand = 10'b1100100000;
    hv = 0;
    for (int i = 0; i < 10; i++) hv = (hv << 1) | int'(seq_a[i]);
    check("prn1_model_head", hv, int'(hand));

    tick(); tick();
    check("rst_rx", int'(RX), 0);
    check("rst_valid", int'(VALID), 0);
    check("rst_epoch", int'(EPOCH), 0);
    check("rst_chip", int'(CHIP), 0);
    check("rst_busy", int'(BUSY), 0);
    check("rst_cfg_err", int'(CFG_ERR), 0);
    RESET_N = 1'b1;
    tick();

    // PRN1 alone from reset configuration; full epoch plus wrap.
    do_start();
    check("start_busy", int'(BUSY), 1);
    check("start_valid_low", int'(VALID), 0);
    tick();
    check("first_valid", int'(VALID), 1);
    check("first_chip_idx", int'(CHIP), 1);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("prn1_chip%0d", i + 1), int'(RX),
            erase_now ? 0 : (hand[9 - i] ? 1 : 3));
      tick();
    end
    run_check("prn1_epoch", 10, 1014, 0, 0, 1'b0, 1'b0);
    do_stop();
    check("stop1_busy", int'(BUSY), 0);
    check("stop1_valid", int'(VALID), 0);

    // Rejected LOAD keeps PRN1; LOAD while busy is ignored.
    do_load(11, 6, 3, 7, 0, 0, 1'b0);
    check("bad_tap_cfg_err", int'(CFG_ERR), 1);
    do_start();
    TAP_A1 = 4'd3; TAP_A2 = 4'd7; LOAD = 1'b1;
    tick();
    LOAD = 1'b0;
    check("busy_load_cfg_err", int'(CFG_ERR), 1);
    run_check("after_bad_load", 0, 20, 0, 0, 1'b0, 1'b0);
    do_stop();
    do_load(2, 6, 3, 7, 0, 0, 1'b0);
    check("good_load_cfg_err", int'(CFG_ERR), 0);
    do_load(2, 6, 3, 7, 1023, 0, 1'b0);
    check("phase1023_cfg_err", int'(CFG_ERR), 1);
    do_load(2, 6, 4, 4, 0, 0, 1'b1);
    check("b_same_tap_en_err", int'(CFG_ERR), 1);
    do_load(2, 6, 4, 4, 0, 0, 1'b0);
    check("b_same_tap_dis_ok", int'(CFG_ERR), 0);
    do_load(2, 6, 0, 7, 0, 0, 1'b0);
    check("b_tap0_err", int'(CFG_ERR), 1);

    // Code-phase advance on channel A only.
    do_load(2, 6, 3, 7, 5, 0, 1'b0);
    do_start();
    check("align_busy", int'(BUSY), 1);
    wait_valid(nv);
    check("align5_latency", nv, 6);
    run_check("phase5", 0, 20, 5, 0, 1'b0, 1'b0);
    do_stop();
    do_load(2, 6, 3, 7, 1022, 0, 1'b0);
    do_start();
    wait_valid(nv);
    check("align1022_latency", nv, 1023);
    run_check("phase1022", 0, 3, 1022, 0, 1'b0, 1'b0);
    do_stop();

    // Two satellites with LOAD and START in the same cycle.
    TAP_A1 = 4'd2; TAP_A2 = 4'd6; TAP_B1 = 4'd3; TAP_B2 = 4'd7;
    PHASE_A = 10'd3; PHASE_B = 10'd7; ENABLE_B = 1'b1;
    LOAD = 1'b1; START = 1'b1; nz = 16'hACE1;
    tick();
    LOAD = 1'b0; START = 1'b0;
    wait_valid(nv);
    check("dual_align_latency", nv, 8);
    run_check("dual_phased", 0, 1023, 3, 7, 1'b1, 1'b1);
    do_stop();
    PHASE_A = 10'd0; PHASE_B = 10'd0;
    LOAD = 1'b1; START = 1'b1; nz = 16'hACE1;
    tick();
    LOAD = 1'b0; START = 1'b0;
    wait_valid(nv);
    check("dual_zero_latency", nv, 1);
    run_check("dual_epoch", 0, 1023, 0, 0, 1'b1, 1'b1);
    do_stop();

    // STOP at chip 500 together with START; STOP wins, restart from chip 1.
    do_load(2, 6, 3, 7, 0, 0, 1'b0);
    do_start();
    nv = 0;
    while (int'(CHIP) != 500 && nv < 2000) begin
      tick();
      nv++;
    end
    check("reach_chip500", int'(CHIP), 500);
    STOP = 1'b1; START = 1'b1;
    tick();
    STOP = 1'b0; START = 1'b0;
    check("stop500_busy", int'(BUSY), 0);
    check("stop500_valid", int'(VALID), 0);
    check("stop500_chip", int'(CHIP), 0);
    check("stop500_rx", int'(RX), 0);
    tick();
    check("stop_wins_idle", int'(BUSY), 0);
    do_start();
    wait_valid(nv);
    check("restart_latency", nv, 1);
    run_check("restart", 0, 10, 0, 0, 1'b0, 1'b0);
    START = 1'b1;
    tick();
    START = 1'b0;
    check("start_in_run_ignored", int'(CHIP), 11);
    do_stop();

    // Asynchronous reset mid-run restores reset configuration and clears CFG_ERR.
    do_load(3, 7, 2, 6, 0, 0, 1'b0);
    do_load(12, 7, 2, 6, 0, 0, 1'b0);
    do_start();
    tick(); tick(); tick();
    RESET_N = 1'b0;
    #1;
    check("async_rst_valid", int'(VALID), 0);
    check("async_rst_busy", int'(BUSY), 0);
    check("async_rst_chip", int'(CHIP), 0);
    check("async_rst_cfg_err", int'(CFG_ERR), 0);
    tick();
    RESET_N = 1'b1;
    tick();
    check("post_rst_no_chip", int'(VALID), 0);
    do_start();
    wait_valid(nv);
    check("post_rst_latency", nv, 1);
    run_check("post_rst_prn1", 0, 10, 0, 0, 1'b0, 1'b0);
    do_stop();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
